// File: rtl/sram_sp_init_ext.sv
// Single-port masked-write SRAM model with a hardware init sweep, ready handshake,
// selectable 1/2-cycle read latency and hold-last read data.
module sram_sp_init_ext #(
    parameter int               WIDTH      = 160,
    parameter int               DEPTH      = 128,
    parameter int               MASK_GRAN  = 40,
    parameter int               LATENCY    = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       RW0_clk,
    input  logic                       reset,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [AW-1:0]              RW0_addr,
    input  logic [WIDTH/MASK_GRAN-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]           RW0_wdata,
    output logic [WIDTH-1:0]           RW0_rdata,
    output logic                       RW0_rvalid,
    output logic                       RW0_ready,
    input  logic                       init_req
);

    localparam int              LANES   = WIDTH / MASK_GRAN;
    localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            addr_ok;
    logic            wr_fire;
    logic            rd_fire;
    logic [WIDTH-1:0] rd_word;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [LANES-1:0] mem_lane_en;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             p1_valid_q, p1_valid_d;
    logic [WIDTH-1:0] p1_data_q, p1_data_d;

    // Sweep/ready state machine: INIT walks every entry once, READY serves requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake: a request is taken on any cycle where RW0_en and RW0_ready are both high;
    // anything presented while RW0_ready is low is discarded without side effects.
    assign RW0_ready = (state_q == ST_READY);
    assign accept    = RW0_en && RW0_ready;
    assign addr_ok   = ({1'b0, RW0_addr} < DEPTH_W);
    assign wr_fire   = accept && RW0_wmode && addr_ok;
    assign rd_fire   = accept && !RW0_wmode;

    always_comb begin
        mem_we      = 1'b0;
        mem_waddr   = RW0_addr;
        mem_lane_en = RW0_wmask;
        mem_wdata   = RW0_wdata;
        if (state_q == ST_INIT) begin
            mem_we      = 1'b1;
            mem_waddr   = cnt_q;
            mem_lane_en = '1;
            mem_wdata   = INIT_VALUE;
        end else begin
            mem_we = wr_fire;
        end
    end

    // The array itself has no reset; the sweep is what clears it.
    always_ff @(posedge RW0_clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lane_en[i]) begin
                    mem_q[mem_waddr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign rd_word = addr_ok ? mem_q[RW0_addr] : '0;

    always_comb begin
        p1_valid_d = rd_fire;
        p1_data_d  = rd_fire ? rd_word : p1_data_q;
    end

    // The read pipeline is not flushed by init_req, so reads in flight finish with pre-sweep data.
    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_data_q  <= p1_data_d;
        end
    end

    // Any LATENCY other than 2 is treated as 1.
    generate
        if (LATENCY == 2) begin : g_lat2
            logic             p2_valid_q, p2_valid_d;
            logic [WIDTH-1:0] p2_data_q, p2_data_d;

            always_comb begin
                p2_valid_d = p1_valid_q;
                p2_data_d  = p1_valid_q ? p1_data_q : p2_data_q;
            end

            always_ff @(posedge RW0_clk or posedge reset) begin
                if (reset) begin
                    p2_valid_q <= 1'b0;
                    p2_data_q  <= '0;
                end else begin
                    p2_valid_q <= p2_valid_d;
                    p2_data_q  <= p2_data_d;
                end
            end

            assign RW0_rvalid = p2_valid_q;
            assign RW0_rdata  = p2_data_q;
        end else begin : g_lat1
            assign RW0_rvalid = p1_valid_q;
            assign RW0_rdata  = p1_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_init_ext.sv
// Bench for sram_sp_init_ext: u0 uses the default configuration, u1 uses LATENCY=2 with DEPTH=100.
module tb_sram_sp_init_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic         rst0, en0, wm0, init0;
    logic [6:0]   addr0;
    logic [3:0]   mask0;
    logic [159:0] wdata0, rdata0;
    logic         rvalid0, ready0;

    logic         rst1, en1, wm1, init1;
    logic [6:0]   addr1;
    logic [3:0]   mask1;
    logic [159:0] wdata1, rdata1;
    logic         rvalid1, ready1;

    logic [159:0] exp0_q[$];
    int           due0_q[$];
    logic [159:0] exp1_q[$];
    int           due1_q[$];

    sram_sp_init_ext u0 (
        .RW0_clk(clk), .reset(rst0), .RW0_en(en0), .RW0_wmode(wm0), .RW0_addr(addr0),
        .RW0_wmask(mask0), .RW0_wdata(wdata0), .RW0_rdata(rdata0), .RW0_rvalid(rvalid0),
        .RW0_ready(ready0), .init_req(init0)
    );

    sram_sp_init_ext #(.LATENCY(2), .DEPTH(100)) u1 (
        .RW0_clk(clk), .reset(rst1), .RW0_en(en1), .RW0_wmode(wm1), .RW0_addr(addr1),
        .RW0_wmask(mask1), .RW0_wdata(wdata1), .RW0_rdata(rdata1), .RW0_rvalid(rvalid1),
        .RW0_ready(ready1), .init_req(init1)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitors: pop the expected queue on every rvalid and check data and arrival cycle.
    always @(negedge clk) begin
        logic [159:0] d;
        int           due;
        if (!rst0 && rvalid0) begin
            if (exp0_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u0_unexpected_rvalid: got rdata %h at cycle %0d, want no response", rdata0, cyc);
            end else begin
                d   = exp0_q.pop_front();
                due = due0_q.pop_front();
                check("u0_rdata", rdata0, d);
                check("u0_rvalid_cycle", 160'(cyc), 160'(due));
            end
        end
    end

    always @(negedge clk) begin
        logic [159:0] d;
        int           due;
        if (!rst1 && rvalid1) begin
            if (exp1_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u1_unexpected_rvalid: got rdata %h at cycle %0d, want no response", rdata1, cyc);
            end else begin
                d   = exp1_q.pop_front();
                due = due1_q.pop_front();
                check("u1_rdata", rdata1, d);
                check("u1_rvalid_cycle", 160'(cyc), 160'(due));
            end
        end
    end

    task automatic drive(input int inst, input logic en, input logic wm, input logic [6:0] a,
                         input logic [3:0] m, input logic [159:0] d, input logic ir);
        @(posedge clk);
        #1;
        if (inst == 0) begin
            en0 = en; wm0 = wm; addr0 = a; mask0 = m; wdata0 = d; init0 = ir;
        end else begin
            en1 = en; wm1 = wm; addr1 = a; mask1 = m; wdata1 = d; init1 = ir;
        end
    endtask

    task automatic wr(input int inst, input logic [6:0] a, input logic [3:0] m, input logic [159:0] d);
        drive(inst, 1'b1, 1'b1, a, m, d, 1'b0);
    endtask

    task automatic rd(input int inst, input logic [6:0] a, input logic [159:0] exp_d, input logic ir);
        drive(inst, 1'b1, 1'b0, a, 4'h0, '0, ir);
        if (inst == 0) begin
            exp0_q.push_back(exp_d);
            due0_q.push_back(cyc + 1);
        end else begin
            exp1_q.push_back(exp_d);
            due1_q.push_back(cyc + 2);
        end
    endtask

    task automatic idle(input int inst);
        drive(inst, 1'b0, 1'b0, 7'd0, 4'h0, '0, 1'b0);
    endtask

    task automatic wait_ready(input int inst, input int exp_cyc, input string name);
        int seen;
        seen = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((inst == 0) ? ready0 : ready1) begin
                seen = cyc;
                break;
            end
        end
        check(name, 160'(seen), 160'(exp_cyc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    logic [159:0] pat_a5, ones, mix, pat_x, pat_a, pat_b, pat_c, pat_y, pat_p, pat_z;
    int k;
    int j;

    initial begin
        pat_a5 = {20{8'hA5}};
        ones   = '1;
        mix    = {40'hA5A5A5A5A5, 40'hFFFFFFFFFF, 40'hA5A5A5A5A5, 40'hFFFFFFFFFF};
        pat_x  = 160'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEF;
        pat_a  = 160'h1111;
        pat_b  = 160'h2222_0000_0000_0000_0000_0000_0000_0000_0000_0000;
        pat_c  = {4{40'h3C3C3C3C3C}};
        pat_y  = 160'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
        pat_p  = 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
        pat_z  = 160'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

        rst0 = 1'b1; en0 = 1'b0; wm0 = 1'b0; addr0 = '0; mask0 = '0; wdata0 = '0; init0 = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; wm1 = 1'b0; addr1 = '0; mask1 = '0; wdata1 = '0; init1 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("u0_reset_ready", 160'(ready0), 160'(0));
        check("u0_reset_rvalid", 160'(rvalid0), 160'(0));
        check("u0_reset_rdata", rdata0, '0);
        check("u1_reset_ready", 160'(ready1), 160'(0));
        check("u1_reset_rvalid", 160'(rvalid1), 160'(0));
        check("u1_reset_rdata", rdata1, '0);

        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        k = cyc;

        // Write issued 10 cycles into the sweep must be dropped.
        repeat (9) @(posedge clk);
        wr(0, 7'd3, 4'hF, ones);
        check("u0_ready_low_mid_sweep", 160'(ready0), 160'(0));
        idle(0);

        wait_ready(1, k + 100, "u1_ready_after_reset");
        wait_ready(0, k + 128, "u0_ready_after_reset");

        rd(0, 7'd127, '0, 1'b0);
        rd(0, 7'd3, '0, 1'b0);
        wr(0, 7'd5, 4'hF, pat_a5);
        rd(0, 7'd5, pat_a5, 1'b0);
        wr(0, 7'd5, 4'b0101, ones);
        rd(0, 7'd5, mix, 1'b0);
        wr(0, 7'd0, 4'b1000, pat_z);
        wr(0, 7'd127, 4'hF, pat_p);
        rd(0, 7'd0, {pat_z[159:120], 120'd0}, 1'b0);
        rd(0, 7'd127, pat_p, 1'b0);
        rd(0, 7'd5, mix, 1'b0);
        idle(0);
        repeat (3) @(negedge clk);
        check("u0_rdata_hold", rdata0, mix);
        check("u0_rvalid_idle", 160'(rvalid0), 160'(0));

        // In-flight read survives init_req issued in the same cycle.
        wr(1, 7'd7, 4'hF, pat_x);
        rd(1, 7'd7, pat_x, 1'b1);
        j = cyc;
        idle(1);
        @(negedge clk);
        check("u1_ready_drop_on_init", 160'(ready1), 160'(0));
        wait_ready(1, j + 101, "u1_ready_after_init_req");
        rd(1, 7'd7, '0, 1'b0);

        wr(1, 7'd1, 4'hF, pat_a);
        wr(1, 7'd2, 4'hF, pat_b);
        wr(1, 7'd3, 4'hF, pat_c);
        rd(1, 7'd1, pat_a, 1'b0);
        rd(1, 7'd2, pat_b, 1'b0);
        rd(1, 7'd3, pat_c, 1'b0);

        wr(1, 7'd100, 4'hF, ones);
        rd(1, 7'd100, '0, 1'b0);
        wr(1, 7'd99, 4'hF, pat_y);
        rd(1, 7'd99, pat_y, 1'b0);
        idle(1);
        repeat (4) @(negedge clk);
        check("u1_rdata_hold", rdata1, pat_y);

        // Reset asserted 50 cycles into a requested sweep.
        drive(1, 1'b0, 1'b0, 7'd0, 4'h0, '0, 1'b1);
        idle(1);
        repeat (49) @(posedge clk);
        #1;
        rst1 = 1'b1;
        @(negedge clk);
        check("u1_midsweep_reset_ready", 160'(ready1), 160'(0));
        check("u1_midsweep_reset_rdata", rdata1, '0);
        check("u1_midsweep_reset_rvalid", 160'(rvalid1), 160'(0));
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        k = cyc;
        wait_ready(1, k + 100, "u1_ready_after_midsweep_reset");
        rd(1, 7'd99, '0, 1'b0);
        idle(1);

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("u0_pending_responses", 160'(exp0_q.size()), 160'(0));
        check("u1_pending_responses", 160'(exp1_q.size()), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
